// File: rtl/fifo_mem.sv
// fifo_mem: storage array with synchronous write and asynchronous read
module fifo_mem #(
    parameter int D_WIDTH = 6,
    parameter int A_WIDTH = 2,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [A_WIDTH-1:0] waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic [A_WIDTH-1:0] raddr,
    output logic [D_WIDTH-1:0] rdata
);
    logic [D_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/vr_fifo_thresh.sv
// vr_fifo_thresh: show-ahead valid/ready FIFO with occupancy count,
// almost-full/almost-empty thresholds and synchronous flush
module vr_fifo_thresh #(
    parameter int D_WIDTH  = 6,
    parameter int A_WIDTH  = 2,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [D_WIDTH-1:0] up_data,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic [A_WIDTH:0]   count,
    output logic               almost_full,
    output logic               almost_empty
);
    localparam int DEPTH = 1 << A_WIDTH;
    localparam int CNT_W = A_WIDTH + 1;
    // a single-entry FIFO still needs a one-bit memory address
    localparam int AW    = (A_WIDTH > 0) ? A_WIDTH : 1;

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
        $error("vr_fifo_thresh: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_chk
        $error("vr_fifo_thresh: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end

    logic [CNT_W-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic             empty, full, push, pop;

    assign wr_addr = AW'(wr_ptr % DEPTH);
    assign rd_addr = AW'(rd_ptr % DEPTH);
    // full: addresses equal, wrap bits differ
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == CNT_W'(DEPTH);

    assign up_ready   = rst & ~flush & ~full;
    assign down_valid = rst & ~flush & ~empty;
    assign push       = up_valid & up_ready;
    assign pop        = down_valid & down_ready;

    assign almost_full  = count >= CNT_W'(AF_LEVEL);
    assign almost_empty = count <= CNT_W'(AE_LEVEL);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
    end

    fifo_mem #(.D_WIDTH(D_WIDTH), .A_WIDTH(AW), .DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_addr),
        .wdata(up_data),
        .raddr(rd_addr),
        .rdata(down_data)
    );
endmodule

// File: tb/tb_vr_fifo_thresh.sv
// tb_vr_fifo_thresh: directed scenario tests for vr_fifo_thresh at default parameters
module tb_vr_fifo_thresh;
    logic       clk = 1'b0;
    logic       rst, flush, up_valid, up_ready, down_valid, down_ready;
    logic [5:0] up_data, down_data;
    logic [2:0] count;
    logic       almost_full, almost_empty;
    int         n_checks = 0;
    int         n_fail = 0;

    vr_fifo_thresh dut (
        .clk(clk), .rst(rst), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL rst_up_ready got %b want 0", up_ready); end
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL rst_down_valid got %b want 0", down_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_ae got %b want 1", almost_empty); end
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_af got %b want 0", almost_full); end
        rst = 1'b1;
        tick();
        n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL idle_up_ready got %b want 1", up_ready); end
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL idle_down_valid got %b want 0", down_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL idle_count got %0d want 0", count); end
    endtask

    task automatic test_fill();
        down_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            up_valid = 1'b1;
            up_data  = 6'(i);
            tick();
            n_checks++; if (count !== 3'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
            n_checks++; if (almost_empty !== (i <= 1)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, i <= 1); end
            n_checks++; if (almost_full !== (i >= 3)) begin n_fail++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, i >= 3); end
            n_checks++; if (up_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_up_ready[%0d] got %b want %b", i, up_ready, i < 4); end
        end
        up_data = 6'h05;
        tick();
        up_valid = 1'b0;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_count got %0d want 4", count); end
    endtask

    task automatic test_drain();
        down_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (down_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got %b want 1", i, down_valid); end
            n_checks++; if (down_data !== 6'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, down_data, 6'(i)); end
            tick();
            n_checks++; if (count !== 3'(4 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 4 - i); end
        end
        down_ready = 1'b0;
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", down_valid); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            up_valid = 1'b1;
            up_data  = 6'(8'h10 + i);
            tick();
        end
        up_data    = 6'h14;
        down_ready = 1'b1;
        n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL fp_ready_full got %b want 0", up_ready); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fp_count_full got %0d want 4", count); end
        n_checks++; if (down_data !== 6'h10) begin n_fail++; $display("FAIL fp_head got %h want 10", down_data); end
        tick();
        down_ready = 1'b0;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fp_count_pop got %0d want 3", count); end
        n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL fp_ready_after got %b want 1", up_ready); end
        tick();
        up_valid = 1'b0;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fp_count_refill got %0d want 4", count); end
        down_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (down_data !== 6'(8'h10 + i)) begin n_fail++; $display("FAIL fp_order[%0d] got %h want %h", i, down_data, 6'(8'h10 + i)); end
            tick();
        end
        down_ready = 1'b0;
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL fp_empty got %b want 0", down_valid); end
    endtask

    task automatic test_wrap();
        logic [5:0] q[$];
        int         sent = 0;
        int         cyc = 0;
        bit         mpush, mpop;
        while ((sent < 20 || q.size() > 0) && cyc < 1000) begin
            up_valid   = (sent < 20) && ($urandom_range(0, 1) == 1);
            up_data    = 6'(sent);
            down_ready = $urandom_range(0, 1) == 1;
            #1;
            n_checks++; if (up_ready !== (q.size() < 4)) begin n_fail++; $display("FAIL wrap_ready c%0d got %b want %b", cyc, up_ready, q.size() < 4); end
            n_checks++; if (down_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL wrap_valid c%0d got %b want %b", cyc, down_valid, q.size() > 0); end
            if (q.size() > 0) begin
                n_checks++; if (down_data !== q[0]) begin n_fail++; $display("FAIL wrap_data c%0d got %h want %h", cyc, down_data, q[0]); end
            end
            mpush = up_valid && q.size() < 4;
            mpop  = down_ready && q.size() > 0;
            tick();
            if (mpop) void'(q.pop_front());
            if (mpush) begin q.push_back(up_data); sent++; end
            n_checks++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL wrap_count c%0d got %0d want %0d", cyc, count, q.size()); end
            cyc++;
        end
        n_checks++; if (cyc >= 1000) begin n_fail++; $display("FAIL wrap_timeout got %0d sent want 20", sent); end
        up_valid   = 1'b0;
        down_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            up_valid = 1'b1;
            up_data  = 6'(8'h30 + i);
            tick();
        end
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fl_count_pre got %0d want 3", count); end
        flush   = 1'b1;
        up_data = 6'h3F;
        #1;
        n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready got %b want 0", up_ready); end
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got %b want 0", down_valid); end
        tick();
        flush    = 1'b0;
        up_valid = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fl_count got %0d want 0", count); end
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid_after got %b want 0", down_valid); end
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL fl_ae got %b want 1", almost_empty); end
        up_valid = 1'b1;
        up_data  = 6'h2A;
        tick();
        up_valid = 1'b0;
        n_checks++; if (down_valid !== 1'b1) begin n_fail++; $display("FAIL fl_new_valid got %b want 1", down_valid); end
        n_checks++; if (down_data !== 6'h2A) begin n_fail++; $display("FAIL fl_new_head got %h want 2a", down_data); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL fl_new_count got %0d want 1", count); end
        down_ready = 1'b1;
        tick();
        down_ready = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fl_final_count got %0d want 0", count); end
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        down_ready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_full_pop();
        test_wrap();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
